// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divide sequencer.
package fp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPECIAL = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_NORM    = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;

endpackage

// File: rtl/fdiv_classify.sv
// Combinational IEEE-754 single operand classifier; denormals count as zero.
module fdiv_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [22:0] frac_o,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);

  always_comb begin
    sign_o    = op_i[31];
    exp_o     = op_i[30:23];
    frac_o    = op_i[22:0];
    is_zero_o = (op_i[30:23] == '0);
    is_inf_o  = (op_i[30:23] == 8'(EXP_MAX)) && (op_i[22:0] == '0);
    is_nan_o  = (op_i[30:23] == 8'(EXP_MAX)) && (op_i[22:0] != '0);
  end

endmodule

// File: rtl/fdiv_sequencer.sv
// Single-precision divide sequencer: resolves special operands directly and
// drives an external mantissa divider core, then normalises and rounds (RNE).
module fdiv_sequencer
  import fp_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      flags,
  output logic            div_start,
  output logic [25:0]     div_dividend,
  output logic [23:0]     div_divisor,
  input  logic            div_done,
  input  logic [25:0]     div_quotient,
  input  logic            div_rem_nz
);

  localparam logic signed [9:0] E_MAX   = 10'(EXP_MAX);
  localparam logic [9:0]        BIAS_HI = 10'(EXP_BIAS);
  localparam logic [9:0]        BIAS_LO = 10'(EXP_BIAS - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic [25:0]     dividend_q, dividend_d;
  logic [23:0]     divisor_q, divisor_d;
  logic [25:0]     quot_q, quot_d;
  logic            rem_nz_q, rem_nz_d;

  // In IDLE the classifiers look at the live operands to pick the next state;
  // afterwards they look at the captured copies.
  logic [XLEN-1:0] cls_a_in, cls_b_in;
  logic            sa, sb, za, zb, ia, ib, na, nb;
  logic [7:0]      ea, eb;
  logic [22:0]     fa, fb;

  assign cls_a_in = (state_q == ST_IDLE) ? op_a : a_q;
  assign cls_b_in = (state_q == ST_IDLE) ? op_b : b_q;

  fdiv_classify u_cls_a (
    .op_i      (cls_a_in),
    .sign_o    (sa),
    .exp_o     (ea),
    .frac_o    (fa),
    .is_zero_o (za),
    .is_inf_o  (ia),
    .is_nan_o  (na)
  );

  fdiv_classify u_cls_b (
    .op_i      (cls_b_in),
    .sign_o    (sb),
    .exp_o     (eb),
    .frac_o    (fb),
    .is_zero_o (zb),
    .is_inf_o  (ib),
    .is_nan_o  (nb)
  );

  logic        res_sign;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;

  always_comb begin
    res_sign   = sa ^ sb;
    spec_res   = '0;
    spec_flags = '0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      spec_res            = QNAN;
      spec_flags[FLAG_NV] = 1'b1;
    end else if (ia) begin
      spec_res = {res_sign, 8'hFF, 23'd0};
    end else if (zb) begin
      spec_res            = {res_sign, 8'hFF, 23'd0};
      spec_flags[FLAG_DZ] = 1'b1;
    end else begin
      spec_res = {res_sign, 31'd0};
    end
  end

  logic              hi, g, s, rnd, carry;
  logic [22:0]       frac, frac_r;
  logic signed [9:0] e_pre, e_fin;
  logic [31:0]       norm_res;
  logic [4:0]        norm_flags;

  // Quotient lies in [2^24, 2^26); bit 25 selects which window is the mantissa.
  always_comb begin
    hi         = quot_q[25];
    frac       = hi ? quot_q[24:2] : quot_q[23:1];
    g          = hi ? quot_q[1] : quot_q[0];
    s          = hi ? (quot_q[0] | rem_nz_q) : rem_nz_q;
    e_pre      = $signed({2'b00, ea} - {2'b00, eb} + (hi ? BIAS_HI : BIAS_LO));
    rnd        = g & (s | frac[0]);
    carry      = rnd & (&frac);
    frac_r     = frac + {22'd0, rnd};
    e_fin      = e_pre + $signed({9'd0, carry});
    norm_res   = '0;
    norm_flags = '0;
    if (e_fin >= E_MAX) begin
      norm_res            = {res_sign, 8'hFF, 23'd0};
      norm_flags[FLAG_OF] = 1'b1;
      norm_flags[FLAG_NX] = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      norm_res            = {res_sign, 31'd0};
      norm_flags[FLAG_UF] = 1'b1;
      norm_flags[FLAG_NX] = 1'b1;
    end else begin
      norm_res            = {res_sign, e_fin[7:0], frac_r};
      norm_flags[FLAG_NX] = g | s;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    flags_d    = flags_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_nz_d   = rem_nz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          a_d        = op_a;
          b_d        = op_b;
          dividend_d = {1'b1, fa, 2'b00};
          divisor_d  = {1'b1, fb};
          state_d    = (za || zb || ia || ib || na || nb) ? ST_SPECIAL : ST_LAUNCH;
        end
      end
      ST_SPECIAL: begin
        result_d = spec_res;
        flags_d  = spec_flags;
        state_d  = ST_RESP;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_done) begin
          quot_d   = div_quotient;
          rem_nz_d = div_rem_nz;
          state_d  = ST_NORM;
        end
      end
      ST_NORM: begin
        result_d = norm_res;
        flags_d  = norm_flags;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_nz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_nz_q   <= rem_nz_d;
    end
  end

  assign req_ready    = rst_n && (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign result       = result_q;
  assign flags        = flags_q;
  assign div_start    = (state_q == ST_LAUNCH);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_fdiv_sequencer.sv
// Self-checking bench for fdiv_sequencer with a behavioural mantissa divider
// core and a queue of expected responses.
module tb_fdiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        div_start;
  logic [25:0] div_dividend;
  logic [23:0] div_divisor;
  logic        div_done;
  logic [25:0] div_quotient;
  logic        div_rem_nz;

  fdiv_sequencer #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .result       (result),
    .flags        (flags),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_rem_nz   (div_rem_nz)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          core_lat = 2;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  // Mantissa divider core: start seen in LAUNCH, done core_lat edges later.
  initial begin : core_model
    logic [63:0] num, den;
    div_done     = 1'b0;
    div_quotient = '0;
    div_rem_nz   = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) begin
        checks++;
        if (div_dividend !== {1'b1, cur_a[22:0], 2'b00} || div_divisor !== {1'b1, cur_b[22:0]}) begin
          errors++;
          $display("FAIL core_operands: got %h/%h expected %h/%h", div_dividend, div_divisor,
                   {1'b1, cur_a[22:0], 2'b00}, {1'b1, cur_b[22:0]});
        end
        num = {15'd0, 1'b1, cur_a[22:0], 25'd0};
        den = {40'd0, 1'b1, cur_b[22:0]};
        repeat (core_lat) @(posedge clk);
        #1;
        div_quotient = 26'(num / den);
        div_rem_nz   = (num % den) != 64'd0;
        div_done     = 1'b1;
        @(posedge clk);
        #1;
        div_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic send_req(input logic [31:0] a, input logic [31:0] b, output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (ok) begin
      cur_a = a;
      cur_b = b;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (req_ready !== 1'b0)     begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    if (rsp_valid !== 1'b0)     begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (result !== 32'd0)       begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    if (flags !== 5'd0)         begin errors++; $display("FAIL reset_flags: got %h expected 0", flags); end
    if (div_start !== 1'b0)     begin errors++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
    if (div_dividend !== 26'd0) begin errors++; $display("FAIL reset_div_dividend: got %h expected 0", div_dividend); end
    if (div_divisor !== 24'd0)  begin errors++; $display("FAIL reset_div_divisor: got %h expected 0", div_divisor); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_first_idle_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_normal();
    logic [31:0] va [7] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h40000000,
                            32'h40400000, 32'h00800000, 32'h7F000000};
    logic [31:0] vb [7] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40400000,
                            32'h40000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vr [7] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h3F2AAAAB,
                            32'h3FC00000, 32'h00800000, 32'h7F000000};
    logic [4:0]  vf [7] = '{5'h00, 5'h01, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00};
    exp_t e;
    int   lat, w;
    bit   ok;
    for (int i = 0; i < 7; i++) begin
      core_lat = 1 + (i % 3);
      sb_q.push_back('{vr[i], vf[i], 3 + core_lat});
      send_req(va[i], vb[i], ok, w);
      if (ok) wait_rsp(lat, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL normal_timeout[%0d]: no response for %h/%h", i, va[i], vb[i]);
      end else begin
        checks += 3;
        if (result !== e.res) begin errors++; $display("FAIL normal_result[%0d]: got %h expected %h", i, result, e.res); end
        if (flags !== e.flg)  begin errors++; $display("FAIL normal_flags[%0d]: got %h expected %h", i, flags, e.flg); end
        if (lat != e.lat)     begin errors++; $display("FAIL normal_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        ack_rsp();
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [10] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7FC00001, 32'h7F800000,
                             32'h7F800000, 32'hBF800000, 32'h00000001, 32'h80000000, 32'h3F800000};
    logic [31:0] vb [10] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'hFF800000,
                             32'h00000000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h00400000};
    logic [31:0] vr [10] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                             32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h7F800000};
    logic [4:0]  vf [10] = '{5'h08, 5'h10, 5'h00, 5'h10, 5'h10, 5'h00, 5'h08, 5'h00, 5'h00, 5'h08};
    exp_t e;
    int   lat, w;
    bit   ok;
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{vr[i], vf[i], 2});
      send_req(va[i], vb[i], ok, w);
      if (ok) wait_rsp(lat, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL special_timeout[%0d]: no response for %h/%h", i, va[i], vb[i]);
      end else begin
        checks += 3;
        if (result !== e.res) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, result, e.res); end
        if (flags !== e.flg)  begin errors++; $display("FAIL special_flags[%0d]: got %h expected %h", i, flags, e.flg); end
        if (lat != e.lat)     begin errors++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        ack_rsp();
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] va [5] = '{32'h7F000000, 32'h00800000, 32'h7F000000, 32'h00800000, 32'hFF000000};
    logic [31:0] vb [5] = '{32'h00800000, 32'h4B000000, 32'h3F000000, 32'h40000000, 32'h3F000000};
    logic [31:0] vr [5] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'hFF800000};
    logic [4:0]  vf [5] = '{5'h05, 5'h03, 5'h05, 5'h03, 5'h05};
    exp_t e;
    int   lat, w;
    bit   ok;
    core_lat = 2;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{vr[i], vf[i], 5});
      send_req(va[i], vb[i], ok, w);
      if (ok) wait_rsp(lat, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL range_timeout[%0d]: no response for %h/%h", i, va[i], vb[i]);
      end else begin
        checks += 3;
        if (result !== e.res) begin errors++; $display("FAIL range_result[%0d]: got %h expected %h", i, result, e.res); end
        if (flags !== e.flg)  begin errors++; $display("FAIL range_flags[%0d]: got %h expected %h", i, flags, e.flg); end
        if (lat != e.lat)     begin errors++; $display("FAIL range_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
        ack_rsp();
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat, w;
    bit   ok;
    core_lat = 2;
    sb_q.push_back('{32'h40400000, 5'h00, 5});
    send_req(32'h40C00000, 32'h40000000, ok, w);
    if (ok) wait_rsp(lat, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_timeout: no response");
    end else begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks += 4;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1", i, rsp_valid); end
        if (result !== e.res)   begin errors++; $display("FAIL bp_result[%0d]: got %h expected %h", i, result, e.res); end
        if (flags !== e.flg)    begin errors++; $display("FAIL bp_flags[%0d]: got %h expected %h", i, flags, e.flg); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
      end
      ack_rsp();
      @(negedge clk);
      checks += 2;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat, w;
    bit   ok;
    core_lat = 3;
    sb_q.push_back('{32'h3EAAAAAB, 5'h01, 6});
    sb_q.push_back('{32'h7F800000, 5'h08, 2});
    send_req(32'h3F800000, 32'h40400000, ok, w);
    if (ok) wait_rsp(lat, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_first_timeout: no response");
    end else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", result, e.res); end
      if (flags !== e.flg)  begin errors++; $display("FAIL b2b_first_flags: got %h expected %h", flags, e.flg); end
      if (lat != e.lat)     begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, e.lat); end
      ack_rsp();
    end
    send_req(32'h3F800000, 32'h00000000, ok, w);
    checks++;
    if (!ok || w != 0) begin errors++; $display("FAIL b2b_ready_next_cycle: waited %0d cycles, accepted %b, expected 0 and 1", w, ok); end
    if (ok) wait_rsp(lat, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_second_timeout: no response");
    end else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", result, e.res); end
      if (flags !== e.flg)  begin errors++; $display("FAIL b2b_second_flags: got %h expected %h", flags, e.flg); end
      if (lat != e.lat)     begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, e.lat); end
      ack_rsp();
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    int   lat, w;
    bit   ok, seen;
    core_lat = 8;
    send_req(32'h40C00000, 32'h40000000, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL midwait_accept: request not accepted"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL midwait_reset_ready: got %b expected 0", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midwait_reset_valid: got %b expected 0", rsp_valid); end
    if (div_dividend !== 26'd0) begin errors++; $display("FAIL midwait_reset_dividend: got %h expected 0", div_dividend); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks += 2;
    if (seen)               begin errors++; $display("FAIL late_done_response: got rsp_valid 1 expected 0"); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL late_done_ready: got %b expected 1", req_ready); end
    core_lat = 2;
    sb_q.push_back('{32'h3EAAAAAB, 5'h01, 5});
    send_req(32'h3F800000, 32'h40400000, ok, w);
    if (ok) wait_rsp(lat, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_timeout: no response");
    end else begin
      checks += 3;
      if (result !== e.res) begin errors++; $display("FAIL post_reset_result: got %h expected %h", result, e.res); end
      if (flags !== e.flg)  begin errors++; $display("FAIL post_reset_flags: got %h expected %h", flags, e.flg); end
      if (lat != e.lat)     begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, e.lat); end
      ack_rsp();
    end
  endtask

  initial begin : main
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdiv_sequencer.md
FDIV_SEQUENCER -- requirements
Module: fdiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand and result width (IEEE-754 single).
REQ-002 CLK  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  operand pair valid.
REQ-005 req_ready  output  1  sequencer can accept; high only in IDLE.
REQ-006 op_a  input  XLEN  dividend.
REQ-007 op_b  input  XLEN  divisor.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 result  output  XLEN  quotient a/b.
REQ-011 flags  output  5  {NV,DZ,OF,UF,NX}, bit 4 = NV.
REQ-012 div_start  output  1  one-cycle launch pulse to the iterative mantissa divider core.
REQ-013 div_dividend  output  26  {1,frac_a,2'b00}, held stable from div_start until div_done.
REQ-014 div_divisor  output  24  {1,frac_b}, held stable from div_start until div_done.
REQ-015 div_done  input  1  one-cycle pulse; quotient and remainder valid.
REQ-016 div_quotient  input  26  floor(div_dividend*2^23 / div_divisor), range [2^24, 2^26).
REQ-017 div_rem_nz  input  1  remainder nonzero.

Function
REQ-018 FSM states: IDLE, SPECIAL, LAUNCH, WAIT, NORM, RESP.
REQ-019 IDLE: req_valid && req_ready captures op_a/op_b; next state SPECIAL if either operand is special, else LAUNCH.
REQ-020 Special classes: exp=0 -> zero (denormals treated as zero); exp=255, frac=0 -> inf; exp=255, frac!=0 -> NaN.
REQ-021 SPECIAL, priority order: any NaN, 0/0 or inf/inf -> 32'h7FC00000, NV; inf/x -> signed inf; finite nonzero/0 -> signed inf, DZ; 0/x or x/inf -> signed zero. Next state RESP.
REQ-022 LAUNCH: div_start=1 for exactly one cycle; next state WAIT.
REQ-023 WAIT: holds until div_done; captures div_quotient and div_rem_nz; next state NORM.
REQ-024 Sign = sign_a XOR sign_b for all non-NaN results.
REQ-025 NORM: if q[25]=1, mant=q[25:2], G=q[1], S=q[0]|rem_nz, e=ea-eb+127; else mant=q[24:1], G=q[0], S=rem_nz, e=ea-eb+126; e is 10-bit signed.
REQ-026 Round to nearest even: increment when G && (S || mant[0]); a carry out of mant sets mant=2^23 and e=e+1.
REQ-027 e>=255 -> signed inf, OF|NX; e<=0 -> signed zero, UF|NX (flush-to-zero); otherwise NX=G|S.
REQ-028 RESP: rsp_valid=1; result and flags stable while rsp_ready=0; on rsp_ready next state IDLE.
REQ-029 Latency from accept edge: special = rsp_valid 2 cycles later; normal = 3 cycles + core latency (start to done).
REQ-030 div_done outside WAIT is ignored; req_valid outside IDLE is not accepted.
REQ-031 Back-to-back: req_ready rises the cycle after the rsp handshake; there is no combinational req_ready/rsp_ready path.

Reset
REQ-032 rst_n low forces IDLE immediately, including mid-WAIT; the in-flight operation is discarded.
REQ-033 Reset values: req_ready=0 while rst_n low, 1 in first IDLE cycle; rsp_valid=0; result=0; flags=0; div_start=0; div_dividend=0; div_divisor=0.
REQ-034 A late div_done from a discarded operation, arriving after reset in IDLE, produces no response.

Structure
REQ-035 Shared package fp_div_pkg: FSM state enum, flag bit indices, QNAN=32'h7FC00000, EXP_BIAS=127, EXP_MAX=255.
REQ-036 One sub-module, fdiv_classify (combinational, per operand: is_zero, is_inf, is_nan, sign, exp, frac), instantiated twice.
REQ-037 The mantissa divider core is external; the sequencer does not contain the division iteration.

Verification
REQ-038 6.0/2.0: 40C00000/40000000 -> result=40400000, flags=0.
REQ-039 1/3: 3F800000/40400000 -> result=3EAAAAAB, flags=NX only.
REQ-040 1/0 -> 7F800000, DZ; 0/0 -> 7FC00000, NV; 1/7F800000 -> 00000000, flags=0; each with rsp_valid 2 cycles after accept.
REQ-041 7F000000/00800000 -> 7F800000, OF|NX; 00800000/4B000000 -> 00000000, UF|NX.
REQ-042 rsp_ready held low 5 cycles -> result/flags stable, req_ready=0; release -> IDLE next cycle.
REQ-043 rst_n pulsed low in WAIT, then div_done pulsed in IDLE -> no rsp_valid; next request completes correctly.
